// File: rtl/cache_nway_ctrl.sv
// N-way set-associative write-back cache with pseudo-LRU replacement and a word-serial
// refill/write-back sequencer between the CPU load/store port and the memory bus.
module cache_nway_ctrl #(
    parameter int unsigned OFFSET_WIDTH = 3,
    parameter int unsigned INDEX_WIDTH  = 7,
    parameter int unsigned WAYS         = 2,
    parameter int unsigned TAG_WIDTH    = 30 - OFFSET_WIDTH - INDEX_WIDTH
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [29:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_byte_en_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        mem_req_o,
    output logic        mem_write_o,
    output logic [29:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        mem_last_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);
    localparam int unsigned BlockSize = 1 << OFFSET_WIDTH;
    localparam int unsigned Sets      = 1 << INDEX_WIDTH;
    localparam int unsigned WayW      = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {StIdle, StLookup, StWback, StFill} state_e;
    state_e state_q, state_d;

    logic [TAG_WIDTH-1:0]    tag_q   [WAYS][Sets];
    logic [31:0]             data_q  [WAYS][Sets*BlockSize];
    logic [WAYS-1:0]         valid_q [Sets];
    logic [WAYS-1:0]         dirty_q [Sets];
    logic [2:0]              plru_q  [Sets];

    logic                    req_write_q;
    logic [29:0]             req_addr_q;
    logic [31:0]             req_wdata_q;
    logic [3:0]              req_be_q;
    logic [OFFSET_WIDTH-1:0] cnt_q, cnt_d;
    logic [WayW-1:0]         victim_q, victim_d;

    logic [TAG_WIDTH-1:0]    req_tag;
    logic [INDEX_WIDTH-1:0]  req_idx;
    logic [OFFSET_WIDTH-1:0] req_off;
    assign req_tag = req_addr_q[29 -: TAG_WIDTH];
    assign req_idx = req_addr_q[OFFSET_WIDTH +: INDEX_WIDTH];
    assign req_off = req_addr_q[OFFSET_WIDTH-1:0];

    logic            hit, inv_found;
    logic [WayW-1:0] hit_way, miss_way;
    logic [1:0]      hw2;
    logic [2:0]      plru_upd;
    logic [31:0]     hit_word, merged;
    logic            beat_last;

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        miss_way  = '0;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (valid_q[req_idx][w] && tag_q[w][req_idx] == req_tag) begin
                hit     = 1'b1;
                hit_way = WayW'(w);
            end
        end
        // Descending scan so the lowest-numbered invalid way wins.
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (!valid_q[req_idx][w]) begin
                inv_found = 1'b1;
                miss_way  = WayW'(w);
            end
        end
        if (!inv_found) begin
            if (WAYS == 2) begin
                miss_way = WayW'(plru_q[req_idx][0]);
            end else if (WAYS == 4) begin
                miss_way = plru_q[req_idx][0] ? WayW'({1'b1, plru_q[req_idx][2]})
                                              : WayW'({1'b0, plru_q[req_idx][1]});
            end
        end
    end

    // PLRU bits point at the least recently used side; a hit points them away.
    always_comb begin
        hw2      = 2'(hit_way);
        plru_upd = plru_q[req_idx];
        if (WAYS == 2) begin
            plru_upd[0] = ~hw2[0];
        end else if (WAYS == 4) begin
            plru_upd[0] = ~hw2[1];
            if (!hw2[1]) plru_upd[1] = ~hw2[0];
            else         plru_upd[2] = ~hw2[0];
        end
    end

    always_comb begin
        hit_word = data_q[hit_way][{req_idx, req_off}];
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = req_be_q[i] ? req_wdata_q[8*i +: 8] : hit_word[8*i +: 8];
        end
    end

    assign beat_last = (cnt_q == '1);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        victim_d     = victim_q;
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        resp_rdata_o = '0;
        mem_req_o    = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        mem_last_o   = 1'b0;
        unique case (state_q)
            StIdle: begin
                req_ready_o = 1'b1;
                if (req_valid_i) state_d = StLookup;
            end
            StLookup: begin
                if (hit) begin
                    resp_valid_o = 1'b1;
                    resp_rdata_o = hit_word;
                    state_d      = StIdle;
                end else begin
                    victim_d = miss_way;
                    state_d  = (valid_q[req_idx][miss_way] && dirty_q[req_idx][miss_way])
                               ? StWback : StFill;
                end
            end
            StWback: begin
                mem_req_o   = 1'b1;
                mem_write_o = 1'b1;
                mem_addr_o  = {tag_q[victim_q][req_idx], req_idx, cnt_q};
                mem_wdata_o = data_q[victim_q][{req_idx, cnt_q}];
                mem_last_o  = beat_last;
                if (mem_ack_i) begin
                    cnt_d = cnt_q + 1'b1;
                    if (beat_last) state_d = StFill;
                end
            end
            StFill: begin
                mem_req_o  = 1'b1;
                mem_addr_o = {req_tag, req_idx, cnt_q};
                mem_last_o = beat_last;
                if (mem_ack_i) begin
                    cnt_d = cnt_q + 1'b1;
                    if (beat_last) state_d = StLookup;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            victim_q    <= '0;
            req_write_q <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_be_q    <= '0;
            for (int s = 0; s < int'(Sets); s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            victim_q <= victim_d;
            if (state_q == StIdle && req_valid_i) begin
                req_write_q <= req_write_i;
                req_addr_q  <= req_addr_i;
                req_wdata_q <= req_wdata_i;
                req_be_q    <= req_byte_en_i;
            end
            if (state_q == StLookup && hit) begin
                plru_q[req_idx] <= plru_upd;
                if (req_write_q) dirty_q[req_idx][hit_way] <= 1'b1;
            end
            if (state_q == StFill && mem_ack_i && beat_last) begin
                valid_q[req_idx][victim_q] <= 1'b1;
                dirty_q[req_idx][victim_q] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == StLookup && hit && req_write_q) begin
            data_q[hit_way][{req_idx, req_off}] <= merged;
        end
        if (state_q == StFill && mem_ack_i) begin
            data_q[victim_q][{req_idx, cnt_q}] <= mem_rdata_i;
            if (beat_last) tag_q[victim_q][req_idx] <= req_tag;
        end
    end

endmodule

// File: tb/tb_cache_nway_ctrl.sv
// Directed bench for cache_nway_ctrl: a recency-ordered set model plus a backing memory
// predicts every cycle of each transaction; literal values pin the model.
module tb_cache_nway_ctrl;
    localparam int OW = 3;
    localparam int IW = 7;
    localparam int NW = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0, req_write = 1'b0;
    logic [29:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        req_ready, resp_valid, mem_req, mem_write, mem_last;
    logic [31:0] resp_rdata, mem_wdata;
    logic [29:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    cache_nway_ctrl #(.OFFSET_WIDTH(OW), .INDEX_WIDTH(IW), .WAYS(NW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_byte_en_i(req_be),
        .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata),
        .mem_req_o(mem_req), .mem_write_o(mem_write), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_last_o(mem_last),
        .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [31:0] mem [int];
    bit          m_valid [NW][128];
    bit          m_dirty [NW][128];
    int          m_tag   [NW][128];
    int          m_stamp [NW][128];
    logic [31:0] m_data  [NW][128][8];
    int          now_t = 0;

    function automatic logic [31:0] rd(input int a);
        if (mem.exists(a)) return mem[a];
        return 32'hD000_0000 | 32'(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < NW; w++)
            for (int s = 0; s < 128; s++) begin
                m_valid[w][s] = 0;
                m_dirty[w][s] = 0;
                m_stamp[w][s] = 0;
            end
    endtask

    // Junk on the request and ack lines while the controller is busy; it must be ignored.
    task automatic scramble();
        req_valid = 1'b1;
        req_write = 1'($urandom);
        req_addr  = 30'($urandom);
        req_wdata = $urandom;
        req_be    = 4'($urandom);
        mem_ack   = 1'b1;
        mem_rdata = $urandom;
    endtask

    // Starts and ends on a falling edge with the controller idle.
    task automatic do_req(input bit wr, input int a, input logic [31:0] wd, input logic [3:0] be,
                          input int stall_b, input int rst_b, output logic [31:0] got);
        int idx, tg, off, hw, vic, nb, nwb, waits;
        int          eaddr [16];
        logic [31:0] ewd   [16];
        bit          hit;
        idx = (a >> 3) & 127;
        tg  = a >> 10;
        off = a & 7;
        hit = 0;
        hw  = 0;
        nb  = 0;
        nwb = 0;
        vic = -1;
        for (int w = 0; w < NW; w++)
            if (m_valid[w][idx] && m_tag[w][idx] == tg) begin
                hit = 1;
                hw  = w;
            end
        if (!hit) begin
            for (int w = 0; w < NW; w++)
                if (!m_valid[w][idx] && vic < 0) vic = w;
            if (vic < 0) begin
                vic = 0;
                for (int w = 1; w < NW; w++)
                    if (m_stamp[w][idx] < m_stamp[vic][idx]) vic = w;
            end
            if (m_valid[vic][idx] && m_dirty[vic][idx])
                for (int k = 0; k < 8; k++) begin
                    eaddr[nb] = (m_tag[vic][idx] << 10) | (idx << 3) | k;
                    ewd[nb]   = m_data[vic][idx][k];
                    nb++;
                end
            nwb = nb;
            for (int k = 0; k < 8; k++) begin
                eaddr[nb] = (tg << 10) | (idx << 3) | k;
                ewd[nb]   = '0;
                nb++;
            end
        end
        got = '0;

        chk("idle_ready", 32'(req_ready), 1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = 30'(a);
        req_wdata = wd;
        req_be    = be;
        @(posedge clk);
        @(negedge clk);
        scramble();
        chk("lookup_ready", 32'(req_ready), 0);
        chk("lookup_mem_req", 32'(mem_req), 0);
        chk("lookup_resp_valid", 32'(resp_valid), 32'(hit));
        if (hit) begin
            got = resp_rdata;
            if (!wr) chk("hit_rdata", resp_rdata, m_data[hw][idx][off]);
        end else begin
            for (int b = 0; b < nb; b++) begin
                waits = (b == stall_b) ? 5 : 0;
                for (int s = 0; s <= waits; s++) begin
                    @(posedge clk);
                    @(negedge clk);
                    chk("beat_mem_req", 32'(mem_req), 1);
                    chk("beat_mem_write", 32'(mem_write), 32'(b < nwb));
                    chk("beat_mem_addr", 32'(mem_addr), eaddr[b]);
                    chk("beat_mem_last", 32'(mem_last), 32'(b == nwb - 1 || b == nb - 1));
                    chk("beat_resp_valid", 32'(resp_valid), 0);
                    chk("beat_ready", 32'(req_ready), 0);
                    if (b < nwb) chk("beat_wdata", mem_wdata, ewd[b]);
                    if (b == rst_b) begin
                        rst_n = 1'b0;
                        #1;
                        chk("rst_mem_req", 32'(mem_req), 0);
                        chk("rst_resp_valid", 32'(resp_valid), 0);
                        mem_ack   = 1'b0;
                        req_valid = 1'b0;
                        model_reset();
                        @(negedge clk);
                        rst_n = 1'b1;
                        return;
                    end
                    mem_ack = (s == waits);
                    if (b >= nwb) mem_rdata = (s == waits) ? rd(eaddr[b]) : 32'hDEAD_BEEF;
                    else if (s == waits) mem[eaddr[b]] = mem_wdata;
                end
            end
            hw = vic;
            m_valid[hw][idx] = 1;
            m_dirty[hw][idx] = 0;
            m_tag[hw][idx]   = tg;
            for (int k = 0; k < 8; k++) m_data[hw][idx][k] = rd((tg << 10) | (idx << 3) | k);
            @(posedge clk);
            @(negedge clk);
            scramble();
            chk("replay_resp_valid", 32'(resp_valid), 1);
            chk("replay_mem_req", 32'(mem_req), 0);
            got = resp_rdata;
            if (!wr) chk("replay_rdata", resp_rdata, m_data[hw][idx][off]);
        end
        now_t++;
        m_stamp[hw][idx] = now_t;
        if (wr) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) m_data[hw][idx][off][8*i +: 8] = wd[8*i +: 8];
            m_dirty[hw][idx] = 1;
        end
        @(posedge clk);
        @(negedge clk);
        chk("done_resp_valid", 32'(resp_valid), 0);
        chk("done_mem_req", 32'(mem_req), 0);
        req_valid = 1'b0;
        mem_ack   = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        model_reset();
        mem[32'h43] = 32'h1122_3344;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_mem_write", 32'(mem_write), 0);
        chk("rst_mem_last", 32'(mem_last), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_req(0, 'h40, 0, 4'h0, -1, -1, r);
        chk("t1_load_40", r, 32'hD000_0040);
        do_req(0, 'h43, 0, 4'h0, -1, -1, r);
        chk("t2_load_43", r, 32'h1122_3344);
        do_req(1, 'h43, 32'hAABB_CCDD, 4'b0011, -1, -1, r);
        do_req(0, 'h43, 0, 4'h0, -1, -1, r);
        chk("t3_merged_43", r, 32'h1122_CCDD);
        do_req(0, 'h440, 0, 4'h0, -1, -1, r);
        chk("t4_load_440", r, 32'hD000_0440);
        do_req(0, 'hC40, 0, 4'h0, -1, -1, r);
        chk("t4_load_c40", r, 32'hD000_0C40);
        chk("t4_wback_43", mem[32'h43], 32'h1122_CCDD);
        do_req(0, 'h845, 0, 4'h0, 3, -1, r);
        chk("t5_load_845", r, 32'hD000_0845);
        do_req(1, 'h1005, 32'h5566_7788, 4'b1100, -1, -1, r);
        do_req(0, 'h1005, 0, 4'h0, -1, -1, r);
        chk("store_miss_1005", r, 32'h5566_1005);
        do_req(0, 'h40, 0, 4'h0, -1, 4, r);
        do_req(0, 'h40, 0, 4'h0, -1, -1, r);
        chk("t6_load_40", r, 32'hD000_0040);
        do_req(0, 'h43, 0, 4'h0, -1, -1, r);
        chk("t6_load_43", r, 32'h1122_CCDD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
